// File: rtl/alu_arbiter.sv
// alu_arbiter
// Shares one combinational 74181-style ALU between the fetch sequencer (f_*)
// and the decode/execute sequencer (e_*).
//
// Handshake (both requesters): x_req is a one-cycle pulse. The operands are
// valid only in that cycle. The op is accepted when x_req is sampled while no
// op from that requester is pending. A req that arrives while the requester
// already has an op pending is dropped silently. x_gnt is high for the one
// cycle in which the op drives alu_*. x_done is high in the following cycle,
// and res_* carry that op's result. There is no back-pressure beyond this:
// a requester must not re-pulse req until it has seen its gnt.
//
// Ports
//   CLK, RST                      clock (posedge) / async active-low reset
//   f_req/mode/sel/a/b/cn         fetch request and operands
//   f_gnt, f_done                 fetch op on ALU / fetch result valid
//   e_*                           same set for decode/exec
//   alu_mode/sel/a/b/cn           registered operands to the ALU
//   alu_f, alu_cout               ALU result inputs
//   res_f, res_carry, res_zero    registered result, shared by both sides
//   busy                          op in flight or any op pending
//   dbg_state_o                   1 while the FSM is in OP
module alu_arbiter #(
    parameter int WIDTH        = 8,
    parameter int FETCH_PRIO   = 1,
    parameter int STARVE_LIMIT = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             f_req,
    input  logic             f_mode,
    input  logic [3:0]       f_sel,
    input  logic [WIDTH-1:0] f_a,
    input  logic [WIDTH-1:0] f_b,
    input  logic             f_cn,
    output logic             f_gnt,
    output logic             f_done,
    input  logic             e_req,
    input  logic             e_mode,
    input  logic [3:0]       e_sel,
    input  logic [WIDTH-1:0] e_a,
    input  logic [WIDTH-1:0] e_b,
    input  logic             e_cn,
    output logic             e_gnt,
    output logic             e_done,
    output logic             alu_mode,
    output logic [3:0]       alu_sel,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_cn,
    input  logic [WIDTH-1:0] alu_f,
    input  logic             alu_cout,
    output logic [WIDTH-1:0] res_f,
    output logic             res_carry,
    output logic             res_zero,
    output logic             busy,
    output logic             dbg_state_o
);

    typedef enum logic {ST_IDLE = 1'b0, ST_OP = 1'b1} state_t;

    typedef struct packed {
        logic             mode;
        logic [3:0]       sel;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cn;
    } op_t;

    // alu_* idle value: logic mode, NOP select, zero operands, no carry.
    localparam op_t        NOP_OP = '{mode: 1'b1, sel: 4'h0, a: '0, b: '0, cn: 1'b1};
    localparam logic       PRIO_F = (FETCH_PRIO != 0);
    localparam logic [2:0] LIMIT  = 3'(STARVE_LIMIT);

    state_t           state_q, state_d;
    logic             f_pend_q, f_pend_d, e_pend_q, e_pend_d;
    op_t              f_buf_q, f_buf_d, e_buf_q, e_buf_d;
    op_t              alu_q, alu_d;
    logic             f_gnt_q, e_gnt_q, f_done_q, e_done_q;
    logic [WIDTH-1:0] res_f_q, res_f_d;
    logic             res_carry_q, res_carry_d, res_zero_q, res_zero_d;
    logic [2:0]       starve_q, starve_d;

    op_t  f_in, e_in, f_op, e_op;
    logic f_cand, e_cand, contend, forced, f_win, e_win, prio_won;

    always_comb begin
        f_in = '{mode: f_mode, sel: f_sel, a: f_a, b: f_b, cn: f_cn};
        e_in = '{mode: e_mode, sel: e_sel, a: e_a, b: e_b, cn: e_cn};

        // A pending op always takes precedence over a new req from the same
        // side: the new req is ignored, so the buffer is the source.
        f_op   = f_pend_q ? f_buf_q : f_in;
        e_op   = e_pend_q ? e_buf_q : e_in;
        f_cand = f_pend_q | f_req;
        e_cand = e_pend_q | e_req;

        contend = f_cand & e_cand;
        forced  = (starve_q == LIMIT);
        // Under contention the priority side wins unless the other side has
        // been passed over LIMIT times in a row.
        f_win    = contend ? (PRIO_F ^ forced) : f_cand;
        e_win    = e_cand & ~f_win;
        prio_won = contend & (f_win == PRIO_F);

        starve_d = '0;
        if (prio_won) begin
            starve_d = forced ? starve_q : starve_q + 3'd1;
        end

        f_pend_d = f_cand & ~f_win;
        e_pend_d = e_cand & ~e_win;
        f_buf_d  = (f_req & ~f_pend_q) ? f_in : f_buf_q;
        e_buf_d  = (e_req & ~e_pend_q) ? e_in : e_buf_q;

        alu_d = NOP_OP;
        if (f_win) begin
            alu_d = f_op;
        end else if (e_win) begin
            alu_d = e_op;
        end
        state_d = (f_win | e_win) ? ST_OP : ST_IDLE;

        // The ALU output is only meaningful while an op drives alu_*.
        res_f_d     = res_f_q;
        res_carry_d = res_carry_q;
        res_zero_d  = res_zero_q;
        if (state_q == ST_OP) begin
            res_f_d     = alu_f;
            res_carry_d = alu_cout;
            res_zero_d  = (alu_f == '0);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= ST_IDLE;
            f_pend_q    <= 1'b0;
            e_pend_q    <= 1'b0;
            f_buf_q     <= '0;
            e_buf_q     <= '0;
            alu_q       <= NOP_OP;
            f_gnt_q     <= 1'b0;
            e_gnt_q     <= 1'b0;
            f_done_q    <= 1'b0;
            e_done_q    <= 1'b0;
            res_f_q     <= '0;
            res_carry_q <= 1'b1;
            res_zero_q  <= 1'b1;
            starve_q    <= '0;
        end else begin
            state_q     <= state_d;
            f_pend_q    <= f_pend_d;
            e_pend_q    <= e_pend_d;
            f_buf_q     <= f_buf_d;
            e_buf_q     <= e_buf_d;
            alu_q       <= alu_d;
            f_gnt_q     <= f_win;
            e_gnt_q     <= e_win;
            f_done_q    <= f_gnt_q;
            e_done_q    <= e_gnt_q;
            res_f_q     <= res_f_d;
            res_carry_q <= res_carry_d;
            res_zero_q  <= res_zero_d;
            starve_q    <= starve_d;
        end
    end

    assign f_gnt       = f_gnt_q;
    assign e_gnt       = e_gnt_q;
    assign f_done      = f_done_q;
    assign e_done      = e_done_q;
    assign alu_mode    = alu_q.mode;
    assign alu_sel     = alu_q.sel;
    assign alu_a       = alu_q.a;
    assign alu_b       = alu_q.b;
    assign alu_cn      = alu_q.cn;
    assign res_f       = res_f_q;
    assign res_carry   = res_carry_q;
    assign res_zero    = res_zero_q;
    assign busy        = (state_q == ST_OP) | f_pend_q | e_pend_q;
    assign dbg_state_o = (state_q == ST_OP);

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single 74181-style ALU between the fetch sequencer (PC increment) and the decode/execute sequencer (logic/arith ops on acc).
- Replaces direct, uncoordinated calls into the ALU interface from both FSMs.
- Each requester posts an op with a one-cycle request pulse. The arbiter buffers the op, schedules it onto the ALU and returns a registered result with a done pulse.
- Sits between the core FSMs and the ALU. The ALU stays combinational.

Parameters:
- WIDTH, 8, datapath width of operands and result.
- FETCH_PRIO, 1, 1 = fetch wins simultaneous contention; 0 = exec wins.
- STARVE_LIMIT, 2, consecutive contended wins by the priority side after which the other side is forced to win once (range 1..7).

Ports:
- CLK  in  1  clock, all state on posedge.
- RST  in  1  asynchronous active-low reset.
- f_req  in  1  fetch request pulse; operands valid same cycle.
- f_mode  in  1  ALU mode (1 = logic, 0 = arith).
- f_sel  in  4  ALU function select.
- f_a, f_b  in  WIDTH  operands.
- f_cn  in  1  carry-in.
- f_gnt  out  1  fetch op is on the ALU this cycle.
- f_done  out  1  fetch result valid on res_* this cycle.
- e_req, e_mode, e_sel, e_a, e_b, e_cn, e_gnt, e_done: same as the f_* ports, for decode/exec.
- alu_mode  out  1  to ALU.
- alu_sel  out  4  to ALU.
- alu_a, alu_b  out  WIDTH  to ALU.
- alu_cn  out  1  to ALU.
- alu_f  in  WIDTH  ALU result.
- alu_cout  in  1  ALU carry-out.
- res_f  out  WIDTH  registered result, shared by both requesters.
- res_carry  out  1  registered alu_cout.
- res_zero  out  1  registered (alu_f == 0).
- busy  out  1  op in flight or any op pending.

Behaviour:
- Reset (async, RST low):
  - State IDLE; pending flags and operand buffers cleared.
  - gnt/done = 0, busy = 0, starve counter = 0.
  - alu_mode = 1, alu_sel = 4'h0 (NOP), alu_a = alu_b = 0, alu_cn = 1.
  - res_f = 0, res_carry = 1, res_zero = 1.
- Request capture:
  - At each posedge, x_req = 1 with x_pend = 0 sets x_pend and latches x_mode/sel/a/b/cn into that requester's buffer.
  - x_req while x_pend = 1 is ignored; the buffer is not overwritten and there is no error.
  - The requester need not hold operands after the req cycle.
- Scheduling (same edge as capture; an in-flight req is eligible immediately):
  - State IDLE or OP with no eligible candidate: go to IDLE.
  - One candidate (pending or capturing): it wins.
  - Both candidates: the priority side wins, unless starve counter == STARVE_LIMIT, in which case the other side wins.
  - On a win, the winner's buffer is copied to the alu_* registers, its pend is cleared, state goes to OP, and x_gnt = 1 for exactly one cycle.
- Starve counter:
  - Increments when the priority side wins while the other side is also a candidate.
  - Clears when the non-priority side wins or when there is no contention.
  - Saturates at STARVE_LIMIT.
- OP state:
  - alu_* are held stable for the whole cycle.
  - At the next posedge: res_f <= alu_f, res_carry <= alu_cout, res_zero <= (alu_f == 0), and done of the granted side = 1 for one cycle.
  - The same edge may grant the next op (back-to-back, throughput one op per cycle).
- Latency: req sampled at edge N → gnt high N..N+1 → done high N+1..N+2 with res_* valid. Contended loser: +1 cycle per op ahead of it.
- res_* hold their value until the next done. gnt and done are never high for both sides in the same cycle.
- A requester re-pulsing req in its own done cycle is a new op. Capture and grant may share an edge only if pend was clear.
- alu_* return to the reset values in IDLE.
- busy = (state == OP) | f_pend | e_pend.
- Reset mid-op: everything returns to reset values immediately. No done is issued for an aborted op. Pending ops are lost; requesters reissue.

Test Plan:
- Single fetch: f_req with mode = 0, sel = F, a = 0x05, cn = 0 at edge N → f_gnt cycle N+1, alu_a = 0x05, f_done cycle N+2 with res_f = 0x06, res_zero = 0, e_gnt/e_done stay 0.
- Simultaneous, FETCH_PRIO = 1: f_req (INC 0x10) and e_req (logic XOR a = 0xF0, b = 0x0F) on the same edge → f_gnt, then e_gnt back-to-back on the next cycle; f_done res_f = 0x11, then e_done res_f = 0xFF.
- Starvation, STARVE_LIMIT = 2: hold e pending, pulse f_req every cycle → grant order f, f, e, f, f, e; no e op waits more than 3 grants.
- Duplicate/buffering: e_req a = 0x33 while e_pend = 1 (blocked behind fetch), second e_req a = 0x44 → only the 0x33 op executes; exactly one e_done.
- Zero flag: e_req logic ALLZERO (mode = 1, sel = C) → res_f = 0x00, res_zero = 1; next op with result 0x01 → res_zero = 0.
- Reset mid-op: deassert RST while f_gnt = 1 and e pending → outputs return to reset values asynchronously, no done; after release, busy = 0 and a new f_req completes in 2 cycles.
